// File: rtl/keypad_input_conditioner.sv
// keypad_input_conditioner: synchronizes, debounces and press-qualifies two keypad buttons, tracks digit count and abandons stale codes
module keypad_input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       ZRAW,
  input  logic       ORAW,
  input  logic       ENBL,
  output logic       ZBUT,
  output logic       OBUT,
  output logic       TOUT,
  output logic [1:0] DCNT
);
  typedef enum logic {S_IDLE, S_HELD} state_t;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sync1, r_sync2, r_db, r_db_d, w_rise;
  logic [1:0][7:0]  r_cnt;
  logic [15:0]      r_idle;
  logic             r_zbut, r_obut, r_tout;
  logic [1:0]       r_dcnt;
  logic             w_fire, w_tmo;
  // Two-flop synchronizers; bit 0 is the "0" button, bit 1 the "1" button. Free-running regardless of enable.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {ORAW, ZRAW};
      r_sync2 <= r_sync1;
    end
  // Debounce: accept a new level after DB_CYCLES consecutive disagreeing samples; disable reloads levels so a held key cannot rise.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      r_db   <= '0;
      r_db_d <= '0;
      r_cnt  <= '0;
    end else if (!ENBL) begin
      r_db   <= r_sync2;
      r_db_d <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_db_d <= r_db;
      for (int b = 0; b < 2; b++)
        if (r_sync2[b] == r_db[b]) r_cnt[b] <= '0;
        else if (r_cnt[b] == 8'(DB_CYCLES - 1)) begin
          r_db[b]  <= r_sync2[b];
          r_cnt[b] <= '0;
        end else r_cnt[b] <= r_cnt[b] + 8'd1;
    end
  // Press qualification: a lone rise from IDLE fires; the idle timeout yields to a press landing on the same cycle.
  always_comb begin
    w_rise      = r_db & ~r_db_d;
    w_fire      = ENBL && r_state == S_IDLE && ^w_rise;
    w_tmo       = ENBL && !w_fire && r_dcnt != 2'd0 && r_idle == 16'(TIMEOUT - 1);
    w_state_nxt = !ENBL ? S_IDLE : |w_rise ? S_HELD : ~|r_db ? S_IDLE : r_state;
  end
  // Press FSM state register.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  // Registered pulses, digit count with wrap on the fourth digit, and the idle counter that arms the timeout.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      r_zbut <= 1'b0;
      r_obut <= 1'b0;
      r_tout <= 1'b0;
      r_dcnt <= '0;
      r_idle <= '0;
    end else begin
      r_zbut <= w_fire & w_rise[0];
      r_obut <= w_fire & w_rise[1];
      r_tout <= w_tmo;
      r_dcnt <= (!ENBL || w_tmo) ? 2'd0 : r_dcnt + {1'b0, w_fire};
      r_idle <= (!ENBL || w_fire || w_tmo || r_dcnt == 2'd0) ? 16'd0 : r_idle + 16'd1;
    end
  assign ZBUT = r_zbut;
  assign OBUT = r_obut;
  assign TOUT = r_tout;
  assign DCNT = r_dcnt;
endmodule

// File: tb/tb_keypad_input_conditioner.sv
// tb_keypad_input_conditioner: directed scenarios plus randomized bouncing presses against a behavioural model
module tb_keypad_input_conditioner;
  localparam int DB = 4;
  localparam int TO = 16;
  logic CLK = 1'b0, RSTN = 1'b0, ZRAW = 1'b0, ORAW = 1'b0, ENBL = 1'b1;
  logic ZBUT, OBUT, TOUT;
  logic [1:0] DCNT;
  int vectors = 0, errs = 0;
  keypad_input_conditioner #(.DB_CYCLES(DB), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .ZRAW(ZRAW), .ORAW(ORAW), .ENBL(ENBL),
    .ZBUT(ZBUT), .OBUT(OBUT), .TOUT(TOUT), .DCNT(DCNT)
  );
  always #5 CLK = ~CLK;
  int n, lastp;
  logic s1z, s2z, s1o, s2o, dbz, dbo, rz, ro, idle_st, ez, eo, et;
  logic [1:0] ed;
  bit hz[$], ho[$];
  function automatic bit settled(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    for (int i = q.size() - DB; i < q.size(); i++) if (q[i] != lvl) return 1'b0;
    return 1'b1;
  endfunction
  initial begin : model
    logic iss, nz, no;
    forever begin
      @(posedge CLK or negedge RSTN);
      if (!RSTN) begin
        n = 0; lastp = 0; ed = 2'd0; idle_st = 1'b1;
        {s1z, s2z, s1o, s2o, dbz, dbo, rz, ro, ez, eo, et} = '0;
        hz.delete(); ho.delete();
      end else begin
        n++;
        if (!ENBL) begin
          {ez, eo, et, rz, ro} = '0;
          ed = 2'd0; idle_st = 1'b1;
          dbz = s2z; dbo = s2o;
          hz.delete(); ho.delete();
        end else begin
          iss = idle_st && (rz ^ ro);
          ez = iss && rz; eo = iss && ro; et = 1'b0;
          if (iss) begin ed = ed + 2'd1; lastp = n; end
          else if (ed != 2'd0 && n - lastp == TO) begin et = 1'b1; ed = 2'd0; end
          if (rz || ro) idle_st = 1'b0;
          else if (!dbz && !dbo) idle_st = 1'b1;
          hz.push_back(s2z); ho.push_back(s2o);
          if (hz.size() > DB) void'(hz.pop_front());
          if (ho.size() > DB) void'(ho.pop_front());
          nz = settled(hz, !dbz) ? !dbz : dbz;
          no = settled(ho, !dbo) ? !dbo : dbo;
          rz = nz && !dbz; ro = no && !dbo;
          dbz = nz; dbo = no;
        end
        s2z = s1z; s1z = ZRAW; s2o = s1o; s1o = ORAW;
      end
    end
  end
  initial begin : compare
    forever begin
      @(negedge CLK);
      vectors++;
      if ({ZBUT, OBUT, TOUT, DCNT} !== {ez, eo, et, ed}) begin
        errs++;
        $display("FAIL cycle %0d outputs: got z=%b o=%b t=%b d=%0d, want z=%b o=%b t=%b d=%0d",
                 n, ZBUT, OBUT, TOUT, DCNT, ez, eo, et, ed);
      end
    end
  end
  int ic, cz, co, ct, fz, fo, ft, dp;
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic clr();
    {ic, cz, co, ct, fz, fo, ft, dp} = '{default: 0};
  endtask
  task automatic run(input int k);
    repeat (k) begin
      @(negedge CLK);
      ic++;
      if (ZBUT) begin cz++; if (fz == 0) fz = ic; dp = DCNT; end
      if (OBUT) begin co++; if (fo == 0) fo = ic; dp = DCNT; end
      if (TOUT) begin ct++; if (ft == 0) ft = ic; end
    end
  endtask
  task automatic press(input bit one);
    if (one) ORAW = 1'b1; else ZRAW = 1'b1;
    run(6);
    ORAW = 1'b0; ZRAW = 1'b0;
    run(6);
  endtask
  initial begin : stim
    bit dz, dq;
    int rate;
    run(3);
    check("reset_outputs", {ZBUT, OBUT, TOUT, DCNT}, 0);
    RSTN = 1'b1;
    run(3);
    clr(); ORAW = 1'b1; run(20); ORAW = 1'b0; run(20);
    check("held_one_pulse_count", co, 1);
    check("held_one_latency", fo, 7);
    check("held_one_dcnt", dp, 1);
    check("timeout_after_pulse", ft, 23);
    check("timeout_count", ct, 1);
    check("timeout_dcnt_cleared", DCNT, 0);
    clr();
    for (int i = 0; i < 6; i++) begin ZRAW = !ZRAW; run(2); end
    check("bounce_no_pulse", cz, 0);
    clr(); ZRAW = 1'b1; run(12);
    check("bounce_then_stable_count", cz, 1);
    check("bounce_then_stable_latency", fz, 7);
    ZRAW = 1'b0; run(30);
    clr(); ZRAW = 1'b1; ORAW = 1'b1; run(15);
    check("simultaneous_no_pulse", cz + co, 0);
    check("simultaneous_dcnt", DCNT, 0);
    ZRAW = 1'b0; ORAW = 1'b0; run(12);
    clr(); ORAW = 1'b1; run(12);
    check("after_release_one_pulse", co, 1);
    ORAW = 1'b0; run(30);
    clr();
    press(1'b1); check("code_digit1", dp, 1);
    press(1'b0); check("code_digit2", dp, 2);
    press(1'b0); check("code_digit3", dp, 3);
    press(1'b0); check("code_digit4_wrap", dp, 0);
    check("code_no_timeout", ct, 0);
    check("code_pulses", co * 10 + cz, 13);
    clr(); ORAW = 1'b1; run(6); ORAW = 1'b0; run(10); ZRAW = 1'b1; run(12); ZRAW = 1'b0; run(30);
    check("tcycle_first_pulse", fo, 7);
    check("tcycle_press_step", fz, 23);
    check("tcycle_dcnt", dp, 2);
    check("tcycle_later_timeout", ft, 39);
    check("tcycle_timeout_count", ct, 1);
    clr(); press(1'b0); ORAW = 1'b1; run(10);
    check("enbl_pre_dcnt", DCNT, 2);
    ENBL = 1'b0; run(3);
    check("enbl_low_dcnt", DCNT, 0);
    clr(); ENBL = 1'b1; run(20);
    check("enbl_held_no_pulse", co, 0);
    ORAW = 1'b0; run(10);
    clr(); ORAW = 1'b1; run(10);
    check("enbl_repress_pulse", co, 1);
    check("enbl_repress_dcnt", DCNT, 1);
    ORAW = 1'b0; ZRAW = 1'b1; run(3);
    #2 RSTN = 1'b0;
    #1 check("async_reset_outputs", {ZBUT, OBUT, TOUT, DCNT}, 0);
    @(negedge CLK); RSTN = 1'b1;
    clr(); run(12);
    check("post_reset_full_debounce", fz, 7);
    ZRAW = 1'b0; run(30);
    dz = 1'b0; dq = 1'b0; rate = 20;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rate = $urandom_range(6, 40);
      if ($urandom_range(0, rate - 1) == 0) dz = !dz;
      if ($urandom_range(0, rate - 1) == 0) dq = !dq;
      ZRAW = ($urandom_range(0, 7) == 0) ? !dz : dz;
      ORAW = ($urandom_range(0, 7) == 0) ? !dq : dq;
      if (ENBL ? $urandom_range(0, 299) == 0 : $urandom_range(0, 9) == 0) ENBL = !ENBL;
      RSTN = ($urandom_range(0, 999) != 0);
      run(1);
    end
    RSTN = 1'b1; ENBL = 1'b1; ZRAW = 1'b0; ORAW = 1'b0;
    run(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
